// File: rtl/bcd_down_counter.sv
// Loadable multi-digit BCD down-counter with start/stop control, optional auto-reload
// on terminal count, and a one-cycle error pulse for rejected commands.
module bcd_down_counter #(
    parameter int DIGITS = 2
) (
    input  logic                  CLK,
    input  logic                  Reset,
    input  logic                  Load,
    input  logic [4*DIGITS-1:0]   D,
    input  logic                  Start,
    input  logic                  Stop,
    input  logic                  En,
    input  logic                  AutoReload,
    output logic [4*DIGITS-1:0]   Q,
    output logic                  TC,
    output logic                  Busy,
    output logic                  Done,
    output logic                  Err
);
    localparam int W = 4 * DIGITS;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         r_state;
    state_t         w_state_next;
    logic [W-1:0]   r_q;
    logic [W-1:0]   w_q_next;
    logic [W-1:0]   r_reload;
    logic [W-1:0]   w_reload_next;
    logic           r_tc;
    logic           w_tc_next;
    logic           r_err;
    logic           w_err_next;

    logic [W-1:0]      w_q_dec;
    logic [DIGITS-1:0] w_borrow;
    logic [DIGITS-1:0] w_d_ok;
    logic              w_q_zero;
    logic              w_q_one;

    // Borrow ripples combinationally through every digit, so a full decrement
    // (e.g. 100 -> 099) completes in one edge.
    assign w_borrow[0] = 1'b1;

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_digit
            logic [3:0] w_dig;
            assign w_dig = r_q[4*gi +: 4];
            assign w_q_dec[4*gi +: 4] = !w_borrow[gi]   ? w_dig :
                                        (w_dig == 4'd0) ? 4'd9  : w_dig - 4'd1;
            assign w_d_ok[gi] = (D[4*gi +: 4] <= 4'd9);
            if (gi < DIGITS - 1) begin : g_borrow
                assign w_borrow[gi+1] = w_borrow[gi] && (w_dig == 4'd0);
            end
        end
    endgenerate

    assign w_q_zero = (r_q == '0);
    assign w_q_one  = (r_q == W'(1));

    always_comb begin
        w_state_next  = r_state;
        w_q_next      = r_q;
        w_reload_next = r_reload;
        w_tc_next     = 1'b0;
        w_err_next    = 1'b0;
        if (Load) begin
            w_state_next = IDLE;
            if (&w_d_ok) begin
                w_q_next      = D;
                w_reload_next = D;
            end else begin
                w_err_next = 1'b1;
            end
        end else if (Stop) begin
            if (r_state == RUN) begin
                w_state_next = IDLE;
            end
        end else if (Start && (r_state == IDLE)) begin
            if (w_q_zero) begin
                w_err_next = 1'b1;
            end else begin
                w_state_next = RUN;
            end
        end else if ((r_state == RUN) && En) begin
            if (w_q_one) begin
                w_tc_next = 1'b1;
                // AutoReload only matters on this terminal edge.
                if (AutoReload) begin
                    w_q_next = r_reload;
                end else begin
                    w_q_next     = '0;
                    w_state_next = DONE;
                end
            end else begin
                w_q_next = w_q_dec;
            end
        end
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            r_state  <= IDLE;
            r_q      <= '0;
            r_reload <= '0;
            r_tc     <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_q      <= w_q_next;
            r_reload <= w_reload_next;
            r_tc     <= w_tc_next;
            r_err    <= w_err_next;
        end
    end

    assign Q    = r_q;
    assign TC   = r_tc;
    assign Err  = r_err;
    assign Busy = (r_state == RUN);
    assign Done = (r_state == DONE);

endmodule
